// File: rtl/l2_mem_ctrl_pkg.sv
// rtl/l2_mem_ctrl_pkg.sv - shared constants, state type and address helper for l2_mem_ctrl
package l2_mem_ctrl_pkg;

  localparam int L2_LINE_SIZE = 64;
  localparam int MEM_TIMEOUT  = 255;
  localparam int LINE_OFF     = 6;
  localparam logic [31:0] LINE_MASK = 32'((1 << LINE_OFF) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_ISSUE,
    S_WB_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP
  } state_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~LINE_MASK;
  endfunction

endpackage

// File: rtl/l2_mem_ctrl.sv
// rtl/l2_mem_ctrl.sv - L2 miss initiator: victim writeback, line fill, watchdog and stats
module l2_mem_ctrl
  import l2_mem_ctrl_pkg::*;
#(
  parameter int LINE_SIZE = L2_LINE_SIZE,
  parameter int TIMEOUT   = MEM_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wb,
  input  logic                   req_fill,
  input  logic [31:0]            req_wb_addr,
  input  logic [LINE_SIZE*8-1:0] req_wb_data,
  input  logic [31:0]            req_fill_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [LINE_SIZE*8-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            mem_addr,
  output logic [LINE_SIZE*8-1:0] mem_wdata,
  output logic                   mem_rd,
  output logic                   mem_wr,
  input  logic [LINE_SIZE*8-1:0] mem_rdata,
  input  logic                   mem_ready,
  output logic [15:0]            stat_reads,
  output logic [15:0]            stat_writes,
  output logic [7:0]             stat_timeouts
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        fill_q;
  logic [31:0] wb_addr_q;
  logic [31:0] fill_addr_q;
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      fill_q        <= 1'b0;
      wb_addr_q     <= '0;
      fill_addr_q   <= '0;
      wait_cnt      <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_timeouts <= '0;
    end else begin
      // strobes default low so each issue state yields exactly one pulse
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            fill_q      <= req_fill;
            wb_addr_q   <= req_wb_addr;
            fill_addr_q <= req_fill_addr;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            // victim data goes straight to the write bus; it is only driven to DRAM under mem_wr
            if (req_wb) mem_wdata <= req_wb_data;
            if (req_wb)        state <= S_WB_ISSUE;
            else if (req_fill) state <= S_RD_ISSUE;
            else               state <= S_RESP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WB_ISSUE: begin
          mem_wr   <= 1'b1;
          mem_addr <= line_align(wb_addr_q);
          wait_cnt <= '0;
          state    <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          if (mem_ready) begin
            if (stat_writes != '1) stat_writes <= stat_writes + 16'd1;
            state <= fill_q ? S_RD_ISSUE : S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_err <= 1'b1;
            if (stat_timeouts != '1) stat_timeouts <= stat_timeouts + 8'd1;
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RD_ISSUE: begin
          mem_rd   <= 1'b1;
          mem_addr <= line_align(fill_addr_q);
          wait_cnt <= '0;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_ready) begin
            rsp_rdata <= mem_rdata;
            if (stat_reads != '1) stat_reads <= stat_reads + 16'd1;
            state <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_err <= 1'b1;
            if (stat_timeouts != '1) stat_timeouts <= stat_timeouts + 8'd1;
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
